// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Round-robin arbiter and sequencer that shares a single multi-cycle packed
// nibble add/sub unit (two independent 4-bit lanes) between NREQ requesters.
// One operation is in flight at a time. An accepted operation first resets the
// unit through its active-low reset for one cycle. It then waits for the unit's
// done pulse, bounded by TIMEOUT cycles. The result is returned tagged with the
// requester index.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester handshake, ready is one-hot or zero
//   req_in1/req_in2     per-requester 8-bit operands, requester i at [8i+7:8i]
//   req_op              per-requester 2-bit op: 0 add, 1 sub, 2/3 illegal
//   au_rst_n            active-low reset to the unit, low for one cycle per op
//   au_in1/au_in2/au_op operands and add_or_sub driven to the unit
//   au_out/au_done      unit result and its done pulse
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_data     requester index and result of the response
//   rsp_err             illegal op or timeout; rsp_data is then zero
module addsub_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_in1,
    input  logic [8*NREQ-1:0] req_in2,
    input  logic [2*NREQ-1:0] req_op,
    output logic              au_rst_n,
    output logic [7:0]        au_in1,
    output logic [7:0]        au_in2,
    output logic [1:0]        au_op,
    input  logic [7:0]        au_out,
    input  logic              au_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_data,
    output logic              rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    // start_q is the requester examined first in the next search, i.e. the
    // round-robin pointer plus one. Resetting it to zero gives requester 0
    // first priority out of reset.
    logic [IDW-1:0] start_q, start_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     in1_q, in1_d;
    logic [7:0]     in2_q, in2_d;
    logic [1:0]     op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     data_q, data_d;
    logic           err_q, err_d;

    logic           found;
    logic [IDW-1:0] win;
    logic [7:0]     winIn1;
    logic [7:0]     winIn2;
    logic [1:0]     winOp;

    // Winner search. Requesters are scanned circularly, starting at start_q.
    // The first requester with valid set wins.
    always_comb begin : pick
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(start_q) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign winIn1 = req_in1[8*win +: 8];
    assign winIn2 = req_in2[8*win +: 8];
    assign winOp  = req_op[2*win +: 2];

    // Next-state and handshake logic. Data registers hold their value unless
    // a state explicitly updates them. The unit operands therefore stay stable
    // from SYNC through the response and keep their last value afterwards.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        op_d      = op_q;
        id_d      = id_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready[win] = rst;
                    start_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    id_d    = win;
                    cnt_d   = '0;
                    if (winOp[1]) begin
                        // Illegal op: answer with an error and leave the unit alone.
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        in1_d   = winIn1;
                        in2_d   = winIn2;
                        op_d    = winOp;
                        state_d = S_SYNC;
                    end
                end
            end
            S_SYNC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done pulse in the last allowed cycle still counts as success.
                if (au_done) begin
                    data_d  = au_out;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. A reset drops any operation in flight without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            start_q <= '0;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // The unit is held in reset whenever the arbiter is in reset. It is also
    // held for the single SYNC cycle so that its internal counter restarts.
    assign au_rst_n  = rst & (state_q != S_SYNC);
    assign au_in1    = in1_q;
    assign au_in2    = in2_q;
    assign au_op     = op_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one packed nibble add/sub unit (2x4-bit lanes, multi-cycle, `is_done` pulse) between NREQ requesters.
- Accepts one operation at a time over a per-requester valid/ready interface.
- Synchronises the unit through the unit's active-low reset, drives the operands, waits for done (with timeout), and returns the result tagged with the requester ID.
- Sits between the core's issue logic and the add/sub datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 16, maximum WAIT cycles before an error response (>=4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_in1  input  8*NREQ  operand A, requester i at [8i+7:8i].
- req_in2  input  8*NREQ  operand B, same packing.
- req_op  input  2*NREQ  0=add, 1=sub, 2/3=illegal.
- au_rst_n  output  1  drives the unit's active-low reset.
- au_in1  output  8  operand A to unit.
- au_in2  output  8  operand B to unit.
- au_op  output  2  add_or_sub to unit.
- au_out  input  8  unit result.
- au_done  input  1  unit is_done.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  requester index of the response.
- rsp_data  output  8  result.
- rsp_err  output  1  1 = illegal op or timeout; rsp_data is then 0.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, round-robin pointer 0 (requester 0 has highest priority first);
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0;
  - au_in1/au_in2/au_op=0, timeout counter 0;
  - au_rst_n=0 while rst=0.
- Reset mid-operation abandons the op: no response is produced, and the requester must re-issue.
- States:
  - IDLE: req_ready is combinational, asserted only for the winner. The winner is the first set req_valid bit searching from ptr+1 (mod NREQ) upward. On handshake (cycle T):
    - latch operands, op, and ID;
    - ptr <= winner;
    - op 2/3 -> RESP with rsp_err=1, unit untouched;
    - otherwise -> SYNC.
  - SYNC (one cycle, T+1):
    - au_rst_n=0, au_in1/au_in2/au_op driven from latches;
    - clear the unit's internal counter;
    - -> WAIT.
  - WAIT:
    - au_rst_n=1, operands held stable; timeout counter increments each cycle.
    - On au_done=1: capture au_out into rsp_data, rsp_err=0, -> RESP.
    - If the counter reaches TIMEOUT with no done: rsp_data=0, rsp_err=1, -> RESP.
    - au_done on the same cycle as the timeout: done wins.
  - RESP:
    - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready=1;
    - on handshake -> IDLE, clear the counter, rsp_valid=0 next cycle.
- Operands and au_op are held from SYNC through the end of RESP. Outside those states, au_in1/au_in2/au_op hold their last value.
- au_done is ignored outside WAIT.
- req_ready=0 in every state except IDLE, so at most one op is in flight.
- Next accept is no earlier than the cycle after the RESP handshake.
- Minimum latency from accept (T) to rsp_valid is T+4 with a 2-cycle unit (SYNC T+1, done T+3, RESP T+4).
- Arithmetic is performed entirely by the unit, per nibble mod 16 with no carry between lanes; the arbiter never modifies data.
- Requesters may deassert req_valid without a handshake. The arbiter holds no state for a requester until it is accepted.
- With a single requester valid, it is granted regardless of ptr.

Test Plan:
- Single add: requester 0, in1=0x35, in2=0x21, op=0 -> rsp_valid at T+4, rsp_id=0, rsp_data=0x56, rsp_err=0; au_rst_n low exactly one cycle at T+1.
- Nibble wrap and sub: requester 2, 0x7F+0x11 op=0 -> rsp_data=0x80; then 0x35-0x21 op=1 -> 0x14; then 0x12-0x34 op=1 -> 0xEE.
- Round robin: req 0, 1, 3 held valid continuously with rsp_ready=1 -> grant order 0,1,3,0,1,3; req_ready never has more than one bit set.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable, all req_ready=0, no new au_rst_n pulse; release -> IDLE next cycle.
- Errors: op=3 -> rsp_err=1, rsp_data=0, no au_rst_n pulse. au_done tied 0 with TIMEOUT=16 -> rsp_err=1 after exactly 16 WAIT cycles. au_done on the timeout cycle -> rsp_err=0.
- Async reset asserted during WAIT -> outputs go to reset values immediately with no clock edge. After release, no stale response appears and requester 0 wins a 0/1 tie.
